// File: rtl/irq_ctrl_pkg.sv
// Shared encodings for the interrupt controller: pc_gen pre-control codes,
// controller state encodings and the vector-address helper.
package irq_ctrl_pkg;

  typedef enum logic [3:0] {
    PC_IGN = 4'b0000,
    PC_KEP = 4'b0001,
    PC_IRQ = 4'b0010,
    PC_RST = 4'b0011,
    PC_RET = 4'b0100
  } pc_prectl_e;

  typedef enum logic [2:0] {
    IRQ_S_RST  = 3'd0,
    IRQ_S_IDLE = 3'd1,
    IRQ_S_TAKE = 3'd2,
    IRQ_S_SERV = 3'd3,
    IRQ_S_RET  = 3'd4
  } irq_state_e;

  // Vector address wraps at 32 bits by construction.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [2:0]  idx,
                                           input logic [31:0] stride);
    return base + (32'(idx) * stride);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder over the eligible
// interrupt requests.
module irq_prio_enc #(
  parameter int unsigned N_SRC = 4
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [2:0]       index,
  output logic [N_SRC-1:0] onehot
);

  // NOTE: every output gets a default before the loop so no path through
  // this block leaves a signal unassigned and infers a latch.
  always_comb begin
    valid  = |req;
    index  = '0;
    onehot = '0;
    // Scanning downward lets the lowest set index overwrite the others.
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (req[i]) begin
        index     = 3'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Non-nesting interrupt controller driving the pc_gen pre-control port:
// edge capture, masking, fixed-priority selection and resume-PC save.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC      = 4,
  parameter logic [31:0] IRQ_BASE   = 32'h0000_0040,
  parameter int unsigned VEC_STRIDE = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             pause,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             mask_wr,
  input  logic [N_SRC-1:0] mask_din,
  input  logic             ret_req,
  input  logic [31:0]      pc_cur,
  output logic [3:0]       pc_prectl,
  output logic [31:0]      irq,
  output logic [31:0]      zz_spc,
  output logic             in_service,
  output logic [2:0]       cause,
  output logic [N_SRC-1:0] irq_ack
);

  irq_state_e       state_q, state_d;
  logic [N_SRC-1:0] prev_src_q, prev_src_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [31:0]      irq_q, irq_d;
  logic [31:0]      zz_spc_q, zz_spc_d;
  logic [2:0]       cause_q, cause_d;

  logic [N_SRC-1:0] rise, eligible, win_onehot;
  logic [2:0]       win_index;
  logic             win_valid, take;

  irq_prio_enc #(.N_SRC(N_SRC)) u_prio (
    .req    (eligible),
    .valid  (win_valid),
    .index  (win_index),
    .onehot (win_onehot)
  );

  // Edge capture and mask run every cycle; only the FSM honours pause.
  always_comb begin
    prev_src_d = irq_src;
    rise       = irq_src & ~prev_src_q;
    eligible   = pending_q & mask_q;
    take       = (state_q == IRQ_S_IDLE) && !pause && win_valid;
    irq_ack    = take ? win_onehot : '0;
    pending_d  = (pending_q & ~irq_ack) | rise;
    mask_d     = mask_wr ? mask_din : mask_q;
  end

  always_comb begin
    state_d    = state_q;
    irq_d      = irq_q;
    cause_d    = cause_q;
    zz_spc_d   = zz_spc_q;
    pc_prectl  = PC_IGN;
    in_service = 1'b0;

    case (state_q)
      IRQ_S_RST:  pc_prectl = PC_RST;
      IRQ_S_TAKE: begin
        pc_prectl  = PC_IRQ;
        in_service = 1'b1;
      end
      IRQ_S_SERV: in_service = 1'b1;
      IRQ_S_RET:  pc_prectl = PC_KEP;
      default:    pc_prectl = PC_IGN;
    endcase

    if (!pause) begin
      case (state_q)
        IRQ_S_RST:  state_d = IRQ_S_IDLE;
        IRQ_S_IDLE: begin
          if (take) begin
            state_d  = IRQ_S_TAKE;
            cause_d  = win_index;
            irq_d    = vec_addr(IRQ_BASE, win_index, 32'(VEC_STRIDE));
            zz_spc_d = pc_cur;
          end
        end
        IRQ_S_TAKE: state_d = IRQ_S_SERV;
        IRQ_S_SERV: if (ret_req) state_d = IRQ_S_RET;
        IRQ_S_RET:  state_d = IRQ_S_IDLE;
        default:    state_d = IRQ_S_RST;
      endcase
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q    <= IRQ_S_RST;
      prev_src_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      irq_q      <= IRQ_BASE;
      zz_spc_q   <= '0;
      cause_q    <= '0;
    end else begin
      state_q    <= state_d;
      prev_src_q <= prev_src_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      irq_q      <= irq_d;
      zz_spc_q   <= zz_spc_d;
      cause_q    <= cause_d;
    end
  end

  assign irq    = irq_q;
  assign zz_spc = zz_spc_q;
  assign cause  = cause_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized
// traffic, with expected interrupt entries scoreboarded against a monitor.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int          N      = 4;
  localparam logic [31:0] BASE   = 32'h0000_0040;
  localparam int          STRIDE = 8;

  logic          clock = 1'b0;
  logic          rst = 1'b0;
  logic          pause = 1'b0;
  logic [N-1:0]  irq_src = '0;
  logic          mask_wr = 1'b0;
  logic [N-1:0]  mask_din = '0;
  logic          ret_req = 1'b0;
  logic [31:0]   pc_cur = '0;
  logic [3:0]    pc_prectl;
  logic [31:0]   irq;
  logic [31:0]   zz_spc;
  logic          in_service;
  logic [2:0]    cause;
  logic [N-1:0]  irq_ack;

  irq_ctrl #(.N_SRC(N), .IRQ_BASE(BASE), .VEC_STRIDE(STRIDE)) dut (
    .clock      (clock),
    .rst        (rst),
    .pause      (pause),
    .irq_src    (irq_src),
    .mask_wr    (mask_wr),
    .mask_din   (mask_din),
    .ret_req    (ret_req),
    .pc_cur     (pc_cur),
    .pc_prectl  (pc_prectl),
    .irq        (irq),
    .zz_spc     (zz_spc),
    .in_service (in_service),
    .cause      (cause),
    .irq_ack    (irq_ack)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] vec;
    logic [2:0]  cause;
    logic [31:0] spc;
    logic [3:0]  ack;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         failures = 0;
  logic [3:0] m_pend = '0;
  logic [3:0] m_mask = '0;
  bit         rnd_pause = 1'b0;
  logic [3:0] prev_pc = PC_RST;
  logic [3:0] last_ack = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the lowest enabled pending index is serviced next.
  function automatic exp_t predict(input logic [3:0] elig, input logic [31:0] spc);
    exp_t e;
    e.cause = '0;
    for (int i = 0; i < N; i++) begin
      if (elig[i]) begin
        e.cause = 3'(i);
        break;
      end
    end
    e.ack = 4'(1) << e.cause;
    e.vec = BASE + 32'(e.cause) * 32'(STRIDE);
    e.spc = spc;
    return e;
  endfunction

  task automatic expect_entry(input logic [31:0] spc);
    exp_t e;
    e = predict(m_pend & m_mask, spc);
    exp_q.push_back(e);
    m_pend &= ~e.ack;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (rnd_pause) pause = ($urandom_range(0, 3) == 0);
  endtask

  task automatic write_mask(input logic [3:0] m);
    tick();
    mask_wr  = 1'b1;
    mask_din = m;
    tick();
    mask_wr  = 1'b0;
    m_mask   = m;
  endtask

  task automatic pulse_src(input logic [3:0] r);
    tick();
    irq_src = r;
    m_pend |= r;
    tick();
    irq_src = '0;
  endtask

  // Called from a SERV cycle: one PC_KEP cycle, then back to idle.
  task automatic do_return();
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    #1;
    check("ret_kep", pc_prectl, PC_KEP);
    check("ret_insvc", in_service, 1'b0);
    tick();
    #1;
    check("ret_idle", pc_prectl, PC_IGN);
  endtask

  // kind 0: SERV, 1: RET, 2: IDLE
  task automatic wait_state(input int kind, input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      case (kind)
        0: ok = in_service && (pc_prectl == PC_IGN);
        1: ok = (pc_prectl == PC_KEP);
        default: ok = !in_service && (pc_prectl == PC_IGN);
      endcase
      if (ok) break;
      tick();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout waiting, pc_prectl=%h in_service=%b", name, pc_prectl, in_service);
    end
  endtask

  // Monitor: every interrupt entry is matched against the scoreboard.
  always @(negedge clock) begin
    if (rst) begin
      if (pause) check("ack_paused", 32'(irq_ack), 32'd0);
      if (irq_ack != '0) last_ack = irq_ack;
      if (pc_prectl == PC_IRQ && prev_pc != PC_IRQ) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_entry: got irq=%h cause=%0d expected no entry", irq, cause);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_irq", irq, mon_e.vec);
          check("sb_cause", 32'(cause), 32'(mon_e.cause));
          check("sb_spc", zz_spc, mon_e.spc);
          check("sb_ack", 32'(last_ack), 32'(mon_e.ack));
          check("sb_insvc", 32'(in_service), 32'd1);
        end
        last_ack = '0;
      end
    end
    prev_pc = pc_prectl;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  r;
    logic [3:0]  m;

    // Reset release
    repeat (3) @(posedge clock);
    #1;
    check("rst_prectl", pc_prectl, PC_RST);
    check("rst_spc", zz_spc, 32'd0);
    check("rst_irq", irq, BASE);
    check("rst_cause", 32'(cause), 32'd0);
    check("rst_insvc", 32'(in_service), 32'd0);
    check("rst_ack", 32'(irq_ack), 32'd0);
    rst = 1'b1;
    #1;
    check("rel_first", pc_prectl, PC_RST);
    tick();
    #1;
    check("rel_idle", pc_prectl, PC_IGN);
    check("rel_spc", zz_spc, 32'd0);

    // Single interrupt
    pc_cur = 32'h0000_1234;
    write_mask(4'b0010);
    tick();
    irq_src = 4'b0010;
    m_pend |= 4'b0010;
    expect_entry(pc_cur);
    tick();
    irq_src = '0;
    #1;
    check("single_ack", 32'(irq_ack), 32'h2);
    check("single_wait", pc_prectl, PC_IGN);
    tick();
    #1;
    check("single_prectl", pc_prectl, PC_IRQ);
    check("single_irq", irq, 32'h48);
    check("single_cause", 32'(cause), 32'd1);
    check("single_spc", zz_spc, 32'h1234);
    check("single_insvc", 32'(in_service), 32'd1);
    tick();
    #1;
    check("single_serv", pc_prectl, PC_IGN);
    check("single_serv_insvc", 32'(in_service), 32'd1);
    do_return();

    // Priority: src0 and src3 together
    pc_cur = 32'h0000_2000;
    write_mask(4'hF);
    tick();
    irq_src = 4'b1001;
    m_pend |= 4'b1001;
    expect_entry(pc_cur);
    expect_entry(pc_cur);
    tick();
    irq_src = '0;
    #1;
    check("prio_ack0", 32'(irq_ack), 32'h1);
    tick();
    #1;
    check("prio_irq0", irq, 32'h40);
    check("prio_take0", pc_prectl, PC_IRQ);
    tick();
    #1;
    check("prio_serv0", 32'(in_service), 32'd1);
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    #1;
    check("prio_kep", pc_prectl, PC_KEP);
    tick();
    #1;
    check("prio_gap", pc_prectl, PC_IGN);
    check("prio_gap_insvc", 32'(in_service), 32'd0);
    check("prio_ack3", 32'(irq_ack), 32'h8);
    tick();
    #1;
    check("prio_take3", pc_prectl, PC_IRQ);
    check("prio_irq3", irq, 32'h58);
    check("prio_cause3", 32'(cause), 32'd3);
    tick();
    #1;
    do_return();

    // Masked rise latches, taken after the mask write
    pc_cur = 32'h0000_3000;
    write_mask(4'b0000);
    pulse_src(4'b0100);
    repeat (3) tick();
    #1;
    check("masked_hold", pc_prectl, PC_IGN);
    check("masked_insvc", 32'(in_service), 32'd0);
    tick();
    mask_wr  = 1'b1;
    mask_din = 4'b0100;
    m_mask   = 4'b0100;
    expect_entry(pc_cur);
    tick();
    mask_wr = 1'b0;
    #1;
    check("masked_ack", 32'(irq_ack), 32'h4);
    tick();
    #1;
    check("masked_take", pc_prectl, PC_IRQ);
    check("masked_cause", 32'(cause), 32'd2);
    tick();
    #1;
    do_return();

    // Pause during TAKE
    pc_cur = 32'h0000_4000;
    write_mask(4'b0001);
    tick();
    irq_src = 4'b0001;
    m_pend |= 4'b0001;
    expect_entry(pc_cur);
    tick();
    irq_src = '0;
    tick();
    #1;
    check("pause_take", pc_prectl, PC_IRQ);
    pause = 1'b1;
    #1;
    check("pause_hold0", pc_prectl, PC_IRQ);
    check("pause_ack0", 32'(irq_ack), 32'd0);
    repeat (2) begin
      tick();
      #1;
      check("pause_hold", pc_prectl, PC_IRQ);
      check("pause_ack", 32'(irq_ack), 32'd0);
    end
    tick();
    pause = 1'b0;
    #1;
    check("pause_release", pc_prectl, PC_IRQ);
    tick();
    #1;
    check("pause_serv", pc_prectl, PC_IGN);
    check("pause_serv_insvc", 32'(in_service), 32'd1);

    // Reset mid-service with a masked request pending
    tick();
    irq_src = 4'b0010;
    tick();
    irq_src = '0;
    #1;
    rst = 1'b0;
    #1;
    check("midrst_insvc", 32'(in_service), 32'd0);
    check("midrst_prectl", pc_prectl, PC_RST);
    check("midrst_spc", zz_spc, 32'd0);
    check("midrst_irq", irq, BASE);
    check("midrst_cause", 32'(cause), 32'd0);
    m_pend = '0;
    m_mask = '0;
    tick();
    rst = 1'b1;
    tick();
    #1;
    check("midrst_idle", pc_prectl, PC_IGN);
    write_mask(4'hF);
    repeat (3) tick();
    #1;
    check("midrst_pend_clear", pc_prectl, PC_IGN);
    check("midrst_no_svc", 32'(in_service), 32'd0);

    // Randomized traffic with random stalls
    rnd_pause = 1'b1;
    for (int it = 0; it < 40; it++) begin
      pc_cur = $urandom;
      write_mask(4'b0000);
      r = 4'($urandom_range(0, 15));
      pulse_src(r);
      m = 4'($urandom_range(0, 15));
      write_mask(m);
      while ((m_pend & m_mask) != 4'b0000) begin
        expect_entry(pc_cur);
        wait_state(0, "rnd_serv");
        if ($urandom_range(0, 1) == 1) begin
          r = 4'($urandom_range(0, 15));
          pulse_src(r);
        end
        ret_req = 1'b1;
        wait_state(1, "rnd_ret");
        ret_req = 1'b0;
        wait_state(2, "rnd_idle");
      end
    end

    rnd_pause = 1'b0;
    pause = 1'b0;
    repeat (5) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller on the requester side of the pc_gen pre-control interface.
- Latches and masks external interrupt sources, chooses one by fixed priority, and drives pc_prectl/irq to redirect fetch to a vector.
- Saves the resume PC and supplies it as zz_spc for the PC_RET path.
- Non-nesting: one interrupt in service at a time; the service ends when the core reports a return.

Parameters:
- N_SRC, 4, number of interrupt source lines (1..8)
- IRQ_BASE, 32'h0000_0040, vector address of source 0
- VEC_STRIDE, 8, byte spacing between consecutive source vectors (multiple of 4)

Ports:
- clock  in  1  core clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset
- pause  in  1  pipeline stall (same signal pc_gen and reg_array receive)
- irq_src  in  N_SRC  level source lines, already synchronous to clock
- mask_wr  in  1  write strobe for the mask register
- mask_din  in  N_SRC  new mask value; 1 = source enabled
- ret_req  in  1  decoded return-from-interrupt (pc_gen ctl == PC_RET)
- pc_cur  in  32  PC of the instruction to resume after the interrupt
- pc_prectl  out  4  pre-control to pc_gen: PC_RST / PC_IRQ / PC_KEP / PC_IGN
- irq  out  32  vector address; valid while pc_prectl == PC_IRQ
- zz_spc  out  32  saved resume PC
- in_service  out  1  high from interrupt entry until the return completes
- cause  out  3  index of the source being serviced
- irq_ack  out  N_SRC  one-hot, one cycle, at entry

Behaviour:
- Reset (rst=0, asynchronous):
  - State = RST, pending = 0, mask = 0, prev_src = 0.
  - zz_spc = 0, cause = 0, irq = IRQ_BASE, irq_ack = 0, in_service = 0.
  - pc_prectl = PC_RST.
- Edge capture (every cycle, independent of pause):
  - prev_src <= irq_src.
  - rise = irq_src & ~prev_src.
  - pending <= (pending & ~irq_ack) | rise. A set on the same bit as an ack wins.
- Mask:
  - If mask_wr, mask <= mask_din.
  - The mask gates selection only; masked rises still latch into pending.
- Selection:
  - eligible = pending & mask.
  - The lowest set index wins.
  - Vector address = IRQ_BASE + index*VEC_STRIDE, computed at 32 bits with wrap.
- State machine (advances only when pause=0; while pause=1 the state and all outputs hold):
  - RST: pc_prectl = PC_RST. After one unpaused cycle, go to IDLE.
  - IDLE: pc_prectl = PC_IGN.
    - If eligible != 0: latch cause and irq, set zz_spc <= pc_cur, assert irq_ack for the winner, go to TAKE.
    - ret_req is ignored in IDLE.
  - TAKE: pc_prectl = PC_IRQ for exactly one unpaused cycle; in_service = 1. Go to SERV.
  - SERV: pc_prectl = PC_IGN; in_service = 1.
    - New eligible requests stay pending.
    - On ret_req, go to RET.
  - RET: pc_prectl = PC_KEP for one cycle to let the PC_RET redirect settle.
    - in_service = 0. Go to IDLE.
    - An interrupt is taken no earlier than the cycle after IDLE is re-entered.
- irq_ack:
  - Asserted only in the IDLE->TAKE transition cycle.
  - Never asserted while pause=1.
- Latency: a rising edge at cycle n (IDLE, enabled, pause=0) latches pending at edge n+1, is selected at edge n+1->n+2, and pc_prectl = PC_IRQ during cycle n+2.
- Simultaneous events:
  - Several eligible sources: the lowest index is taken; the others remain pending.
  - mask_wr in the same cycle as selection: the old mask is used.
  - Reset asserted mid-service: abandons the service; all outputs return to reset values immediately.

Decomposition:
- PC_IGN, PC_IRQ, PC_KEP, PC_RST and PC_RET come from the shared mips789_defs.v.
- Add the IRQ state encodings (IRQ_S_RST/IDLE/TAKE/SERV/RET) to mips789_defs.v.
- One sub-module: irq_prio_enc. It is a combinational lowest-index priority encoder with outputs valid, index[2:0] and onehot[N_SRC-1:0].

Test Plan:
- Reset release: hold rst=0 for 3 cycles, then release with pause=0 -> pc_prectl = PC_RST for 1 cycle, then PC_IGN; zz_spc = 0.
- Single interrupt: mask=4'b0010, pulse irq_src[1] with pc_cur = 32'h0000_1234 ->
  - pc_prectl = PC_IRQ for one cycle, irq = 32'h48, cause = 1, irq_ack = 4'b0010;
  - zz_spc = 32'h1234, in_service = 1.
- Priority: mask=4'hF, raise src[3] and src[0] in the same cycle ->
  - src 0 is taken (irq = 32'h40);
  - after ret_req, one PC_KEP cycle, one IDLE cycle, then src 3 is taken (irq = 32'h58).
- Masked latch: mask=0, pulse src[2], then write mask=4'b0100 -> interrupt taken with cause = 2 after the mask write.
- Pause: pause=1 during TAKE for 3 cycles -> pc_prectl stays PC_IRQ, irq_ack stays low, state is held; after release, exactly one PC_IRQ cycle.
- Reset mid-service: assert rst in SERV -> in_service = 0 and pc_prectl = PC_RST immediately; pending is cleared.
